// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Redirect/fetch bundle between execute/trap logic, fetch and
//               the program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int XLEN = 64
) ();
    logic            trap_en;
    logic [XLEN-1:0] trap_pc;
    logic            jump_en;
    logic [XLEN-1:0] jump_pc;
    logic            halt_req;
    logic            inst_is_c;
    logic            pc_ready;
    logic            pc_valid;
    logic [XLEN-1:0] pc;
    logic            redirect;
    logic            misalign;
    logic [XLEN-1:0] misalign_addr;

    // Master: the environment (redirect sources plus the fetch acceptor).
    modport master (
        output trap_en, trap_pc, jump_en, jump_pc, halt_req, inst_is_c, pc_ready,
        input  pc_valid, pc, redirect, misalign, misalign_addr
    );

    modport slave (
        input  trap_en, trap_pc, jump_en, jump_pc, halt_req, inst_is_c, pc_ready,
        output pc_valid, pc, redirect, misalign, misalign_addr
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with BOOT/RUN/HALT control, fetch
//               handshake, prioritised trap/jump redirects and misaligned
//               jump detection. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h8000_0000,
    parameter int              IALIGN       = 32
) (
    input  wire           clk,
    input  wire           rst,
    pc_sequencer_if.slave bus
);

    // Any IALIGN other than 16 behaves as 32-bit alignment.
    localparam bit              c_compressed = (IALIGN == 16);
    localparam logic [XLEN-1:0] c_mask       = c_compressed ? XLEN'(1) : XLEN'(3);
    localparam logic [XLEN-1:0] c_step_c     = XLEN'(2);
    localparam logic [XLEN-1:0] c_step_full  = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_redirect;
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_addr;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_trap_target;
    logic            w_jump_misaligned;

    assign w_step            = (c_compressed && bus.inst_is_c) ? c_step_c : c_step_full;
    assign w_trap_target     = bus.trap_pc & ~c_mask;
    assign w_jump_misaligned = |(bus.jump_pc & c_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_BOOT;
            r_pc            <= RESET_VECTOR;
            r_pc_valid      <= 1'b0;
            r_redirect      <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            // Event pulses fall back to zero unless re-asserted below.
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_RUN;
                    r_pc_valid <= 1'b1;
                end
                S_RUN: begin
                    if (bus.trap_en) begin
                        r_pc       <= w_trap_target;
                        r_redirect <= 1'b1;
                    end else if (bus.jump_en) begin
                        if (w_jump_misaligned) begin
                            r_pc_valid      <= 1'b0;
                            r_misalign      <= 1'b1;
                            r_misalign_addr <= bus.jump_pc;
                            r_state         <= S_HALT;
                        end else begin
                            r_pc       <= bus.jump_pc;
                            r_redirect <= 1'b1;
                        end
                    end else if (bus.halt_req) begin
                        r_pc_valid <= 1'b0;
                        r_state    <= S_HALT;
                    end else if (bus.pc_ready) begin
                        // pc_valid is always high in RUN, so ready alone marks a transfer.
                        r_pc <= r_pc + w_step;
                    end
                end
                S_HALT: begin
                    if (bus.trap_en) begin
                        r_pc       <= w_trap_target;
                        r_pc_valid <= 1'b1;
                        r_redirect <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_pc       <= RESET_VECTOR;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pc_valid      = r_pc_valid;
    assign bus.redirect      = r_redirect;
    assign bus.misalign      = r_misalign;
    assign bus.misalign_addr = r_misalign_addr;

endmodule
`default_nettype wire
